// File: rtl/packet_check.sv
// Egress packet checker: parses generator framing, verifies header/payload,
// reports one metadata word per packet plus transit latency and error flags.
module packet_check #(
  parameter logic [45:0] MAC_BASE  = 46'h0,
  parameter logic [1:0]  MY_PORT   = 2'd0,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [31:0]          in_data,
  input  logic [21:0]          cur_time,
  output logic                 meta_valid,
  output logic [31:0]          meta_out,
  output logic [21:0]          latency,
  output logic [3:0]           err,
  output logic [CNT_WIDTH-1:0] good_cnt,
  output logic [CNT_WIDTH-1:0] bad_cnt
);

  localparam int unsigned TS_W  = 22;
  localparam int unsigned LEN_W = 6;
  localparam int unsigned PAY_W = 9;

  typedef enum logic [2:0] {
    WAIT_W0, DMAC_LO, TS, RSVD, SRC0, SRC1, PAYLOAD, DROP
  } state_e;

  state_e               state_q, state_d;
  logic [LEN_W-1:0]     len_blocks_q, len_blocks_d;
  logic [1:0]           dst_q, dst_d;
  logic [1:0]           src_q, src_d;
  logic [TS_W-1:0]      ts_q, ts_d;
  logic [3:0]           err_acc_q, err_acc_d;
  logic [PAY_W-1:0]     pay_cnt_q, pay_cnt_d;
  logic                 meta_valid_q, meta_valid_d;
  logic [31:0]          meta_out_q, meta_out_d;
  logic [TS_W-1:0]      latency_q, latency_d;
  logic [3:0]           err_q, err_d;
  logic [CNT_WIDTH-1:0] good_cnt_q, good_cnt_d;
  logic [CNT_WIDTH-1:0] bad_cnt_q, bad_cnt_d;

  logic [LEN_W-1:0]     w0_len_blocks;
  logic                 w0_len_err;
  logic                 pay_bad;
  logic [3:0]           err_final;

  assign w0_len_blocks = in_data[26:21];
  assign w0_len_err    = (in_data[20:16] != 5'd0) || (in_data[31:27] != 5'd0) ||
                         (w0_len_blocks == 6'd0);
  assign pay_bad       = (in_data != 32'hFFFF_FFFF);
  assign err_final     = err_acc_q | {pay_bad, 3'b000};

  // Next-state, header parsing and completion reporting
  always_comb begin
    state_d      = state_q;
    len_blocks_d = len_blocks_q;
    dst_d        = dst_q;
    src_d        = src_q;
    ts_d         = ts_q;
    err_acc_d    = err_acc_q;
    pay_cnt_d    = pay_cnt_q;
    meta_valid_d = 1'b0;
    meta_out_d   = meta_out_q;
    latency_d    = latency_q;
    err_d        = err_q;
    good_cnt_d   = good_cnt_q;
    bad_cnt_d    = bad_cnt_q;

    if (state_q == DROP) begin
      if (!in_valid) state_d = WAIT_W0;
    end else if (in_valid) begin
      unique case (state_q)
        WAIT_W0: begin
          len_blocks_d = w0_len_blocks;
          if (w0_len_err) begin
            state_d      = DROP;
            meta_valid_d = 1'b1;
            meta_out_d   = {4'b0000, w0_len_blocks, 22'h0};
            err_d        = 4'b0001;
            if (bad_cnt_q != {CNT_WIDTH{1'b1}}) bad_cnt_d = bad_cnt_q + CNT_WIDTH'(1);
          end else begin
            state_d   = DMAC_LO;
            // Upper MAC bits are checked here so W0 need not be stored
            err_acc_d = {2'b00, in_data[15:0] != MAC_BASE[45:30], 1'b0};
            pay_cnt_d = PAY_W'({w0_len_blocks, 3'b000}) - PAY_W'(6);
          end
        end
        DMAC_LO: begin
          state_d = TS;
          dst_d   = in_data[1:0];
          if ((in_data[31:2] != MAC_BASE[29:0]) || (in_data[1:0] != MY_PORT))
            err_acc_d[1] = 1'b1;
        end
        TS: begin
          state_d = RSVD;
          ts_d    = in_data[21:0];
          if (in_data[31:22] != 10'd0) err_acc_d[2] = 1'b1;
        end
        RSVD: begin
          state_d = SRC0;
          if (in_data != 32'd0) err_acc_d[2] = 1'b1;
        end
        SRC0: begin
          state_d = SRC1;
          src_d   = in_data[1:0];
          if (in_data[31:2] != 30'd0) err_acc_d[2] = 1'b1;
        end
        SRC1: begin
          state_d = PAYLOAD;
          if (in_data != {30'd0, src_q}) err_acc_d[2] = 1'b1;
        end
        PAYLOAD: begin
          err_acc_d = err_final;
          pay_cnt_d = pay_cnt_q - PAY_W'(1);
          if (pay_cnt_q == PAY_W'(1)) begin
            state_d      = WAIT_W0;
            meta_valid_d = 1'b1;
            meta_out_d   = {src_q, dst_q, len_blocks_q, ts_q};
            latency_d    = cur_time - ts_q;
            err_d        = err_final;
            if (err_final == 4'd0) begin
              if (good_cnt_q != {CNT_WIDTH{1'b1}}) good_cnt_d = good_cnt_q + CNT_WIDTH'(1);
            end else begin
              if (bad_cnt_q != {CNT_WIDTH{1'b1}}) bad_cnt_d = bad_cnt_q + CNT_WIDTH'(1);
            end
          end
        end
        default: state_d = WAIT_W0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= WAIT_W0;
      len_blocks_q <= '0;
      dst_q        <= '0;
      src_q        <= '0;
      ts_q         <= '0;
      err_acc_q    <= '0;
      pay_cnt_q    <= '0;
      meta_valid_q <= 1'b0;
      meta_out_q   <= '0;
      latency_q    <= '0;
      err_q        <= '0;
      good_cnt_q   <= '0;
      bad_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      len_blocks_q <= len_blocks_d;
      dst_q        <= dst_d;
      src_q        <= src_d;
      ts_q         <= ts_d;
      err_acc_q    <= err_acc_d;
      pay_cnt_q    <= pay_cnt_d;
      meta_valid_q <= meta_valid_d;
      meta_out_q   <= meta_out_d;
      latency_q    <= latency_d;
      err_q        <= err_d;
      good_cnt_q   <= good_cnt_d;
      bad_cnt_q    <= bad_cnt_d;
    end
  end

  assign meta_valid = meta_valid_q;
  assign meta_out   = meta_out_q;
  assign latency    = latency_q;
  assign err        = err_q;
  assign good_cnt   = good_cnt_q;
  assign bad_cnt    = bad_cnt_q;

endmodule

// File: tb/tb_packet_check.sv
// Scoreboard bench for packet_check: expectations queued as packets are driven,
// popped and compared on each meta_valid pulse.
module tb_packet_check;

  localparam logic [45:0] MAC_BASE  = 46'h1234_5678_9AB;
  localparam logic [1:0]  MY_PORT   = 2'd1;
  localparam int unsigned CNT_WIDTH = 3;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 in_valid;
  logic [31:0]          in_data;
  logic [21:0]          cur_time;
  logic                 meta_valid;
  logic [31:0]          meta_out;
  logic [21:0]          latency;
  logic [3:0]           err;
  logic [CNT_WIDTH-1:0] good_cnt;
  logic [CNT_WIDTH-1:0] bad_cnt;

  typedef struct {
    logic [31:0] meta;
    logic [21:0] lat;
    logic [3:0]  err;
    bit          chk_lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   exp_good = 0;
  int   exp_bad  = 0;
  localparam int CNT_MAX = (1 << CNT_WIDTH) - 1;

  packet_check #(.MAC_BASE(MAC_BASE), .MY_PORT(MY_PORT), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .cur_time(cur_time), .meta_valid(meta_valid), .meta_out(meta_out),
    .latency(latency), .err(err), .good_cnt(good_cnt), .bad_cnt(bad_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Scoreboard: compare every metadata pulse against the oldest expectation
  always @(negedge clk) begin
    if (!reset && meta_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_meta", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("meta_out", meta_out, e.meta);
        check("err", 32'(err), 32'(e.err));
        if (e.chk_lat) check("latency", 32'(latency), 32'(e.lat));
        if (e.err == 4'd0) begin
          if (exp_good < CNT_MAX) exp_good++;
        end else begin
          if (exp_bad < CNT_MAX) exp_bad++;
        end
        check("good_cnt", 32'(good_cnt), 32'(exp_good));
        check("bad_cnt", 32'(bad_cnt), 32'(exp_bad));
      end
    end
  end

  task automatic put_word(input logic [31:0] d, input logic [21:0] t, input bit gaps);
    if (gaps) begin
      for (int g = 0; g < 3 && $urandom_range(1) == 1; g++) begin
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = $urandom;
        cur_time = 22'($urandom);
      end
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    cur_time = t;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 32'hDEAD_BEEF;
    end
  endtask

  task automatic send_pkt(input logic [5:0] lb, input logic [1:0] dport, input logic [21:0] ts,
                          input logic [31:0] w4, input logic [31:0] w5, input int bad_idx,
                          input logic [21:0] last_t, input bit gaps, input int abort_at);
    logic [47:0] dmac;
    logic [15:0] len_bytes;
    logic [31:0] w;
    int          n;
    exp_t        e;
    dmac      = {MAC_BASE, dport};
    len_bytes = {5'd0, lb, 5'd0};
    n         = int'(lb) * 8;
    if (abort_at < 0) begin
      e.meta    = {w4[1:0], dport, lb, ts};
      e.lat     = last_t - ts;
      e.err     = {bad_idx >= 0, (w4 != w5) || (w4[31:2] != 30'd0), dport != MY_PORT, 1'b0};
      e.chk_lat = 1'b1;
      exp_q.push_back(e);
    end
    for (int i = 0; i < n; i++) begin
      if (i == abort_at) return;
      case (i)
        0:       w = {len_bytes, dmac[47:32]};
        1:       w = dmac[31:0];
        2:       w = {10'd0, ts};
        3:       w = 32'd0;
        4:       w = w4;
        5:       w = w5;
        default: w = (i - 6 == bad_idx) ? 32'hFFFF_FFFE : 32'hFFFF_FFFF;
      endcase
      put_word(w, (i == n - 1) ? last_t : 22'($urandom), gaps && i > 0);
    end
  endtask

  initial begin
    exp_t e;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 32'd0;
    cur_time = 22'd0;
    repeat (2) @(negedge clk);
    check("rst_meta_valid", 32'(meta_valid), 32'd0);
    check("rst_meta_out", meta_out, 32'd0);
    check("rst_cnts", 32'({good_cnt, bad_cnt}), 32'd0);
    reset = 1'b0;

    // Minimal packet with fixed latency
    send_pkt(6'd1, MY_PORT, 22'h100, 32'd2, 32'd2, -1, 22'h10A, 1'b0, -1);
    idle(3);

    // Longest packet with random gaps, then a back-to-back short packet
    send_pkt(6'd63, MY_PORT, 22'h2_3456, 32'd3, 32'd3, -1, 22'h2_5000, 1'b1, -1);
    send_pkt(6'd1, MY_PORT, 22'h7, 32'd0, 32'd0, -1, 22'h9, 1'b0, -1);
    idle(3);

    // Single corrupted payload word
    send_pkt(6'd2, MY_PORT, 22'h55, 32'd1, 32'd1, 4, 22'h60, 1'b0, -1);
    idle(2);

    // Illegal length: dropped until a gap, then a clean packet
    e.meta = {4'b0000, 6'd1, 22'h0}; e.lat = 22'd0; e.err = 4'b0001; e.chk_lat = 1'b0;
    exp_q.push_back(e);
    put_word(32'h0021_0000, 22'h0, 1'b0);
    put_word(32'h0020_0000, 22'h0, 1'b0);
    put_word(32'h1234_5678, 22'h0, 1'b0);
    put_word(32'hFFFF_FFFF, 22'h0, 1'b0);
    idle(1);
    send_pkt(6'd1, MY_PORT, 22'h3, 32'd0, 32'd0, -1, 22'h4, 1'b0, -1);
    idle(2);

    // Wrong port, mismatched source words, latency across time wrap
    send_pkt(6'd1, 2'd2, 22'h3F_FFF0, 32'd1, 32'd2, -1, 22'h00_0010, 1'b0, -1);
    idle(3);

    // Reset during payload discards the packet and clears everything
    send_pkt(6'd2, MY_PORT, 22'h11, 32'd0, 32'd0, -1, 22'h0, 1'b0, 10);
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    reset    = 1'b0;
    exp_good = 0;
    exp_bad  = 0;
    check("rst2_meta_valid", 32'(meta_valid), 32'd0);
    check("rst2_meta_out", meta_out, 32'd0);
    check("rst2_latency", 32'(latency), 32'd0);
    check("rst2_err", 32'(err), 32'd0);
    check("rst2_cnts", 32'({good_cnt, bad_cnt}), 32'd0);
    idle(2);
    send_pkt(6'd1, MY_PORT, 22'h20, 32'd1, 32'd1, -1, 22'h25, 1'b0, -1);

    // Enough good packets to saturate the narrow good counter
    for (int k = 0; k < 8; k++)
      send_pkt(6'd1, MY_PORT, 22'(k * 7), 32'(k % 4), 32'(k % 4), -1, 22'(k * 7 + 20), 1'b0, -1);
    idle(5);
    check("drain", 32'(exp_q.size()), 32'd0);
    check("sat_good_cnt", 32'(good_cnt), 32'(CNT_MAX));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/packet_check.md
Name: packet_check

Overview:
- Receive-side counterpart of the switch packet generator: consumes the 32-bit word stream a generator emits, parses the header, verifies framing and payload, and reports one metadata word per packet.
- Sits on an egress port of the switch fabric.
- Reconstructs the packed metadata word `{src[1:0], dst[1:0], len_blocks[5:0], ts[21:0]}`.
- Computes transit latency against a shared free-running time base.
- Keeps saturating good/error packet counters for software readback.

Parameters:
- `MAC_BASE`, `46'h0`: upper 46 bits shared by every port MAC; port MAC = `{MAC_BASE, port[1:0]}`.
- `MY_PORT`, `2'd0`: port index this checker sits on; destination must match.
- `CNT_WIDTH`, `16`: width of the statistics counters.

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: synchronous, active-high reset.
- `in_valid`, in, 1: `in_data` holds a packet word this cycle.
- `in_data`, in, 32: packet word.
- `cur_time`, in, 22: free-running timestamp, same base as the generator.
- `meta_valid`, out, 1: one-cycle pulse, `meta_out`/`latency`/`err` valid.
- `meta_out`, out, 32: `{src[1:0], dst[1:0], len_blocks[5:0], ts[21:0]}`.
- `latency`, out, 22: `(cur_time at last word − ts) mod 2^22`.
- `err`, out, 4: `{payload_err, src_err, mac_err, len_err}`.
- `good_cnt`, out, `CNT_WIDTH`: packets with `err == 0`.
- `bad_cnt`, out, `CNT_WIDTH`: packets with `err != 0`, including dropped ones.

Behaviour:
- Framing, in word order:
  - W0 = `{len_bytes[15:0], dmac[47:32]}`
  - W1 = `dmac[31:0]`
  - W2 = `{10'b0, ts[21:0]}`
  - W3 = `32'h0`
  - W4 = W5 = `{30'b0, src[1:0]}`
  - then P payload words, each `32'hFFFF_FFFF`.
- Length arithmetic:
  - `len_blocks` = `len_bytes[10:5]`.
  - Total words = `len_blocks*8`; P = `len_blocks*8 − 6`, which is 2..498.
  - Payload counter is 9 bits, loaded at W0.
- `len_err` when any of these holds: `len_bytes[4:0] != 0`, `len_bytes[15:11] != 0`, or `len_blocks == 0`. The length error is detected at W0.
- States: `WAIT_W0` → `DMAC_LO` → `TS` → `RSVD` → `SRC0` → `SRC1` → `PAYLOAD` → `WAIT_W0`, plus `DROP`.
  - Each transition advances only on an `in_valid` cycle.
  - Cycles with `in_valid` low hold state; gaps mid-packet are legal.
- `len_err` at W0:
  - Go to `DROP`; the packet is discarded.
  - `meta_valid` pulses next cycle with `err = 4'b0001`, `meta_out` dst/src = 0, and `len_blocks` as received.
  - `bad_cnt` increments.
  - `DROP` ignores words until one cycle with `in_valid` low, then returns to `WAIT_W0`.
- Non-fatal checks, accumulated in a sticky error register cleared at W0:
  - `mac_err`: `dmac[47:2] != MAC_BASE`, or `dmac[1:0] != MY_PORT`. dst field = `dmac[1:0]` regardless.
  - `src_err`: W4 ≠ W5, or bits [31:2] of W4/W5 nonzero, or W3 nonzero, or W2[31:22] nonzero. src field = W4[1:0].
  - `payload_err`: any payload word ≠ all-ones.
- Completion:
  - On the last payload word (counter reaches 1 on a valid cycle), `latency` is captured using that cycle's `cur_time`.
  - `meta_valid` asserts the following cycle; latency from last word to `meta_valid` is exactly 1 cycle.
  - The same cycle, exactly one of `good_cnt`/`bad_cnt` increments.
- Back-to-back packets: W0 of the next packet may arrive the cycle right after the last payload word; it is accepted without a bubble.
- Counters saturate at all-ones; they never wrap.
- Reset:
  - `meta_valid`, `meta_out`, `latency`, `err`, `good_cnt`, `bad_cnt` all 0; state `WAIT_W0`.
  - A reset mid-packet discards the partial packet with no `meta_valid` and no count.

Test Plan:
1. `len_blocks=1` (W0=`32'h0020_0000`, dmac = `{MAC_BASE,MY_PORT}`), ts=`22'h100`, src=2, 2 payload words all-ones, `cur_time=22'h10A` at last word → `meta_valid` 1 cycle later, `meta_out={2'd2,MY_PORT,6'd1,22'h100}`, `latency=10`, `err=0`, `good_cnt=1`.
2. `len_blocks=63`, `in_valid` toggled 50% random; second packet's W0 back-to-back after last word → two `meta_valid` pulses, 498 payload words counted for the first, no lost words.
3. One payload word `32'hFFFF_FFFE` in an otherwise valid packet → `err=4'b1000`, `bad_cnt=1`, `good_cnt` unchanged.
4. W0=`32'h0021_0000` (`len_bytes=33`) → `meta_valid` next cycle with `err=4'b0001`; following words ignored until a 1-cycle gap; then a valid packet parses correctly.
5. dest MAC low bits ≠ `MY_PORT` and W4=1, W5=2 → `err=4'b0110`; ts=`22'h3FFFF0`, `cur_time=22'h000010` → `latency=22'h20`.
6. Reset asserted at `PAYLOAD` mid-packet → outputs and counters 0, no `meta_valid`; next packet parses normally.
